branch_predictor: RTL

- Parametrised branch-target buffer with per-entry N-bit saturating direction counters, for the 5-stage pipelined MIPS core.
- Replaces the single-entry hit/PCCache predictor.
- Looks up the fetch PC combinationally in F.
- Registers the prediction into D.
- Detects mispredictions in D and trains the table from resolved branch/jump outcomes.

---
 rtl/branch_predictor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch-target buffer with per-entry saturating direction counters.
// Lookup is combinational in F; the prediction is registered into D and trained from D.
module branch_predictor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCF,
  output logic              HitF,
  output logic              TakenF,
  output logic [ADDR_W-1:0] PCPredF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic [ADDR_W-1:0] PCD,
  input  logic              UpdateD,
  input  logic              IsJumpD,
  input  logic              ActualTakenD,
  input  logic [ADDR_W-1:0] TargetD,
  output logic              HitD,
  output logic              PredTakenD,
  output logic              MispredictD,
  output logic [ADDR_W-1:0] RecoverPCD,
  output logic [31:0]       MispredictCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  // Only the MSB set: weakly taken for any counter width, including 1.
  localparam logic [CNT_W-1:0] CntWeak = CntMax ^ (CntMax >> 1);

  logic              validTab  [ENTRIES];
  logic [TAG_W-1:0]  tagTab    [ENTRIES];
  logic [ADDR_W-1:0] targetTab [ENTRIES];
  logic [CNT_W-1:0]  cntTab    [ENTRIES];
  logic              jmpTab    [ENTRIES];

  logic [ADDR_W-1:0] predPCD;

  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxD;
  logic [TAG_W-1:0] tagF;
  logic [TAG_W-1:0] tagD;

  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[ADDR_W-1:IDX_W+2];
  assign idxD = PCD[IDX_W+1:2];
  assign tagD = PCD[ADDR_W-1:IDX_W+2];

  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCD[1:0]};

  // Fetch-side lookup
  assign HitF    = validTab[idxF] && (tagTab[idxF] == tagF);
  assign TakenF  = HitF && (jmpTab[idxF] || cntTab[idxF][CNT_W-1]);
  assign PCPredF = TakenF ? targetTab[idxF] : PCF + ADDR_W'(4);

  // Decode-side resolution
  logic trainEn;
  logic hitTrain;

  assign trainEn     = UpdateD && !StallD;
  assign hitTrain    = validTab[idxD] && (tagTab[idxD] == tagD);
  assign MispredictD = trainEn && ((PredTakenD != ActualTakenD) ||
                                   (ActualTakenD && (predPCD != TargetD)));
  assign RecoverPCD  = ActualTakenD ? TargetD : PCD + ADDR_W'(4);

  logic              wrEn;
  logic [CNT_W-1:0]  newCnt;
  logic [ADDR_W-1:0] newTarget;
  logic              newJmp;

  always_comb begin
    wrEn      = 1'b0;
    newCnt    = cntTab[idxD];
    newTarget = targetTab[idxD];
    newJmp    = jmpTab[idxD];
    if (trainEn) begin
      if (hitTrain) begin
        wrEn = 1'b1;
        if (IsJumpD) begin
          newCnt    = CntMax;
          newJmp    = 1'b1;
          newTarget = TargetD;
        end else if (ActualTakenD) begin
          newCnt    = (cntTab[idxD] == CntMax) ? CntMax : cntTab[idxD] + CNT_W'(1);
          newJmp    = 1'b0;
          newTarget = TargetD;
        end else begin
          newCnt = (cntTab[idxD] == '0) ? '0 : cntTab[idxD] - CNT_W'(1);
        end
      end else if (ActualTakenD) begin
        // Direct-mapped allocation overwrites whatever aliased into this slot.
        wrEn      = 1'b1;
        newCnt    = IsJumpD ? CntMax : CntWeak;
        newJmp    = IsJumpD;
        newTarget = TargetD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        validTab[i] <= 1'b0;
        cntTab[i]   <= '0;
        jmpTab[i]   <= 1'b0;
      end
      HitD            <= 1'b0;
      PredTakenD      <= 1'b0;
      predPCD         <= '0;
      MispredictCount <= '0;
    end else begin
      if (wrEn) begin
        validTab[idxD]  <= 1'b1;
        tagTab[idxD]    <= tagD;
        targetTab[idxD] <= newTarget;
        cntTab[idxD]    <= newCnt;
        jmpTab[idxD]    <= newJmp;
      end

      if (FlushD) begin
        HitD       <= 1'b0;
        PredTakenD <= 1'b0;
        predPCD    <= '0;
      end else if (!StallD) begin
        HitD       <= HitF;
        PredTakenD <= TakenF;
        predPCD    <= PCPredF;
      end

      if (MispredictD && (MispredictCount != '1)) begin
        MispredictCount <= MispredictCount + 32'd1;
      end
    end
  end

endmodule
